// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM state encoding,
// segment bit positions and a helper that assembles a segment pattern.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } disp_state_t;

    // Segment bit positions, a..g -> bit 0..6
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'b0;

    // Build an active-high segment word from individual segment flags
    function automatic logic [6:0] seg_bits(input logic a, input logic b, input logic c,
                                            input logic d, input logic e, input logic f,
                                            input logic g);
        logic [6:0] r;
        r        = SEG_OFF;
        r[SEG_A] = a;
        r[SEG_B] = b;
        r[SEG_C] = c;
        r[SEG_D] = d;
        r[SEG_E] = e;
        r[SEG_F] = f;
        r[SEG_G] = g;
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Purely combinational hex-to-7-segment decoder, active-high segments a..g.
module seg7_hex_decoder
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Lookup of the glyph for each hex digit (lower-case b and d)
    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = seg_bits(1, 1, 1, 1, 1, 1, 0);
            4'h1: seg = seg_bits(0, 1, 1, 0, 0, 0, 0);
            4'h2: seg = seg_bits(1, 1, 0, 1, 1, 0, 1);
            4'h3: seg = seg_bits(1, 1, 1, 1, 0, 0, 1);
            4'h4: seg = seg_bits(0, 1, 1, 0, 0, 1, 1);
            4'h5: seg = seg_bits(1, 0, 1, 1, 0, 1, 1);
            4'h6: seg = seg_bits(1, 0, 1, 1, 1, 1, 1);
            4'h7: seg = seg_bits(1, 1, 1, 0, 0, 0, 0);
            4'h8: seg = seg_bits(1, 1, 1, 1, 1, 1, 1);
            4'h9: seg = seg_bits(1, 1, 1, 1, 0, 1, 1);
            4'hA: seg = seg_bits(1, 1, 1, 0, 1, 1, 1);
            4'hB: seg = seg_bits(0, 0, 1, 1, 1, 1, 1);
            4'hC: seg = seg_bits(1, 0, 0, 1, 1, 1, 0);
            4'hD: seg = seg_bits(0, 1, 1, 1, 1, 0, 1);
            4'hE: seg = seg_bits(1, 0, 0, 1, 1, 1, 1);
            4'hF: seg = seg_bits(1, 0, 0, 0, 1, 1, 1);
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_mux_7s.sv
// Time-multiplexed scan controller for NDIG common-anode 7-segment digits.
// One shared decoder, a blank-then-show slot per digit, and a double-buffered
// display value that only changes at frame boundaries.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_mux_7s
    import disp_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    output logic              pend,
    output logic              frame,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);

    disp_state_t       state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [DW-1:0]     digit_reg, digit_next;
    logic              frame_w;

    logic [4*NDIG-1:0] shadow_reg, disp_reg;
    logic              pend_reg;
    logic [NDIG-1:0]   an_reg, an_next;
    logic [6:0]        seg_reg, seg_next;

    logic [3:0]        nib [NDIG];
    logic [6:0]        dec_seg;
    logic              show_w;
    logic              blank_w;
    logic              xfer_w;

    // Scan state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            digit_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            digit_reg <= digit_next;
        end
    end

    // Next-state: dark lead-in of each slot, then lit until the slot ends
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        digit_next = digit_reg;
        frame_w    = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            digit_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    digit_next = '0;
                end
                ST_BLANK: begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(BLANK - 1))
                        state_next = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_reg == CW'(DIV - 1)) begin
                        cnt_next   = '0;
                        state_next = ST_BLANK;
                        if (digit_reg == LAST_DIG) begin
                            digit_next = '0;
                            frame_w    = 1'b1;
                        end else begin
                            digit_next = digit_reg + DW'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    digit_next = '0;
                end
            endcase
        end
    end

    // Display value may change at a frame boundary or while the display is dark
    assign xfer_w = frame_w || (state_reg == ST_IDLE);

    // Load handshake: shadow captures, displayed value updates on xfer
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg <= '0;
            disp_reg   <= '0;
            pend_reg   <= 1'b0;
        end else begin
            if (load)
                shadow_reg <= value;
            if (xfer_w) begin
                if (load) begin
                    disp_reg <= value;
                    pend_reg <= 1'b0;
                end else if (pend_reg) begin
                    disp_reg <= shadow_reg;
                    pend_reg <= 1'b0;
                end
            end else if (load) begin
                pend_reg <= 1'b1;
            end
        end
    end

    // Nibble mux feeding the single shared decoder
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib
        assign nib[gi] = disp_reg[4*gi +: 4];
    end

    seg7_hex_decoder u_dec (
        .hex (nib[digit_reg]),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIG-1:0] lz;
    // lz[i]: nibble i and every nibble above it are zero
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_lz
        assign lz[gi] = (disp_reg[4*NDIG-1:4*gi] == '0);
    end
    assign blank_w = lz[digit_reg] && (digit_reg != '0);
`else
    assign blank_w = 1'b0;
`endif

    // Gating with en makes the pins go dark on the cycle right after en drops
    assign show_w = en && (state_reg == ST_SHOW);

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_an
        assign an_next[gi] = ~(show_w && (digit_reg == DW'(gi)));
    end

    assign seg_next = (show_w && !blank_w) ? dec_seg : SEG_OFF;

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            an_reg  <= '1;
            seg_reg <= SEG_OFF;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an    = an_reg;
    assign seg   = seg_reg;
    assign pend  = pend_reg;
    assign frame = frame_w;

endmodule

// File: tb/tb_display_mux_7s.sv
// Directed bench for display_mux_7s with NDIG=4, DIV=8, BLANK=2.
// cyc counts rising edges since the scan was (re)enabled; outputs are sampled
// 1 time unit after each edge.
module tb_display_mux_7s;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        pend;
    logic        frame;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    display_mux_7s #(.NDIG(4), .DIV(8), .BLANK(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .value (value),
        .pend  (pend),
        .frame (frame),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end else begin
            $display("ok   %s cyc=%0d value=%h", tag, cyc, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (!frame && n < 100) begin
            tick();
            n++;
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    logic [3:0] an_tab [12] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE,
                                4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h00);
        check("rst_pend", pend, 1'b0);
        check("rst_frame", frame, 1'b0);

        // Scan start: 2 dark, 6 lit per slot, blank value shows '0'
        rst = 1'b0;
        en  = 1'b1;
        cyc = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("scan_an", an, an_tab[k]);
            check("scan_seg", seg, (an_tab[k] == 4'hF) ? 7'h00 : 7'h3F);
        end
        wait_frame();
        check("frame1_pos", cyc, 32);
        tick();
        check("frame_pulse_end", frame, 1'b0);

        // Load mid-frame: pending until the frame boundary
        run_to(40);
        do_load(16'h1234);
        check("load_pend", pend, 1'b1);
        run_to(44);
        check("old_an", an, 4'hD);
        check("old_seg", seg, 7'h3F);
        wait_frame();
        check("frame2_pos", cyc, 64);
        check("pend_at_frame", pend, 1'b1);
        tick();
        check("pend_cleared", pend, 1'b0);
        run_to(68);  check("d0_an", an, 4'hE); check("d0_seg", seg, 7'h66);
        run_to(76);  check("d1_an", an, 4'hD); check("d1_seg", seg, 7'h4F);
        run_to(84);  check("d2_an", an, 4'hB); check("d2_seg", seg, 7'h5B);
        run_to(92);  check("d3_an", an, 4'h7); check("d3_seg", seg, 7'h06);

        // Two loads in one frame: last wins
        run_to(97);
        do_load(16'hAAAA);
        run_to(99);
        do_load(16'h5555);
        check("dbl_pend", pend, 1'b1);
        run_to(128);
        check("frame4", frame, 1'b1);
        tick();
        check("dbl_pend_clr", pend, 1'b0);
        run_to(132); check("dbl_d0_seg", seg, 7'h6D);
        run_to(140); check("dbl_d1_an", an, 4'hD); check("dbl_d1_seg", seg, 7'h6D);

        // Load coincident with frame: direct update, pend never set
        run_to(160);
        check("frame5", frame, 1'b1);
        do_load(16'h01AC);
        check("coin_pend", pend, 1'b0);
        tick();
        check("coin_pend2", pend, 1'b0);
        run_to(164); check("coin_d0_seg", seg, 7'h39);
        run_to(172); check("coin_d1_an", an, 4'hD); check("coin_d1_seg", seg, 7'h77);

        // en dropped mid-SHOW: dark next cycle, restart at digit 0 with BLANK
        en = 1'b0;
        tick();
        check("en0_an", an, 4'hF);
        check("en0_seg", seg, 7'h00);
        check("en0_frame", frame, 1'b0);
        tick();
        check("en0_an2", an, 4'hF);
        en  = 1'b1;
        cyc = 0;
        run_to(3);  check("re_an_dark", an, 4'hF);
        run_to(4);  check("re_an_d0", an, 4'hE); check("re_seg_d0", seg, 7'h39);

        // Reset mid-frame with a pending load discards it
        do_load(16'h9999);
        check("rst_pre_pend", pend, 1'b1);
        run_to(12);
        check("rst_pre_an", an, 4'hD);
        check("rst_pre_seg", seg, 7'h77);
        rst = 1'b1;
        tick();
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_seg", seg, 7'h00);
        check("mid_rst_pend", pend, 1'b0);
        check("mid_rst_frame", frame, 1'b0);
        rst = 1'b0;
        cyc = 0;
        run_to(4);  check("post_rst_an", an, 4'hE); check("post_rst_seg", seg, 7'h3F);
        run_to(12); check("post_rst_d1", seg, 7'h3F);
        run_to(33); check("post_rst_pend", pend, 1'b0);
        run_to(36); check("post_rst_disp0", seg, 7'h3F);

        // Leading-zero handling, value 0x0040 then 0x0000
        run_to(37);
        do_load(16'h0040);
        run_to(68);  check("lz40_d0", seg, 7'h3F);
        run_to(76);  check("lz40_d1", seg, 7'h66);
        run_to(84);  check("lz40_d2_an", an, 4'hB); check("lz40_d2", seg, LZ ? 7'h00 : 7'h3F);
        run_to(92);  check("lz40_d3_an", an, 4'h7); check("lz40_d3", seg, LZ ? 7'h00 : 7'h3F);
        run_to(93);
        do_load(16'h0000);
        run_to(100); check("lz0_d0", seg, 7'h3F);
        run_to(108); check("lz0_d1", seg, LZ ? 7'h00 : 7'h3F);
        run_to(116); check("lz0_d2", seg, LZ ? 7'h00 : 7'h3F);
        run_to(124); check("lz0_d3_an", an, 4'h7); check("lz0_d3", seg, LZ ? 7'h00 : 7'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
